// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, status flag positions, the buffered entry
// layout and the flag derivation used when a result is captured.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 1;
  localparam int FLG_P = 0;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] flags;
    logic [7:0] result;
  } alu_entry_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Carry only has meaning for the arithmetic ops; logic ops report C=0.
  function automatic logic [3:0] calc_flags(input logic [7:0] result,
                                            input logic       cout,
                                            input logic [1:0] op);
    logic [3:0] flags;
    flags = 4'b0000;
    case (op)
      OP_ADD, OP_SUB: flags[FLG_C] = cout;
      default:        flags[FLG_C] = 1'b0;
    endcase
    flags[FLG_Z] = (result == 8'h00);
    flags[FLG_N] = result[7];
    flags[FLG_P] = even_parity(result);
    return flags;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic show-ahead synchronous FIFO with an explicit occupancy counter and
// registered full/empty; the head word reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests: a pop frees a slot, so a full FIFO may push and pop together.
  always_comb begin
    pop_s  = pop && !empty_r;
    push_s = push && (!full_r || pop_s);
  end

  // Storage write; contents need no reset since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10: begin
          count_r <= count_r + CW'(1);
          full_r  <= (count_r == CW'(DEPTH - 1));
          empty_r <= 1'b0;
        end
        2'b01: begin
          count_r <= count_r - CW'(1);
          full_r  <= 1'b0;
          empty_r <= (count_r == CW'(1));
        end
        default: begin
          count_r <= count_r;
          full_r  <= full_r;
          empty_r <= empty_r;
        end
      endcase
    end
  end

  // Show-ahead head word.
  always_comb begin
    if (empty_r) begin
      dout = '0;
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results with derived status flags into a FIFO behind a
// ready/valid port; results arriving with no room are counted as drops.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_result,
  input  logic                     in_cout,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [1:0]               out_op,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     overflow_err,
  input  logic                     clr_err
);

  alu_entry_t        wr_entry_s;
  alu_entry_t        rd_entry_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic [DROP_W-1:0] drop_count_r;
  logic              overflow_err_r;

  // Entry assembly and handshake qualification.
  always_comb begin
    wr_entry_s.op     = in_op;
    wr_entry_s.flags  = calc_flags(in_result, in_cout, in_op);
    wr_entry_s.result = in_result;
    pop_s             = !empty && out_ready;
    push_s            = in_valid && (!full || pop_s);
    drop_s            = in_valid && full && !pop_s;
  end

  sync_fifo #(
    .WIDTH ($bits(alu_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wr_entry_s),
    .dout  (rd_entry_s),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Drop accounting; a clear wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_r   <= '0;
      overflow_err_r <= 1'b0;
    end else if (clr_err) begin
      drop_count_r   <= '0;
      overflow_err_r <= 1'b0;
    end else if (drop_s) begin
      overflow_err_r <= 1'b1;
      if (drop_count_r != {DROP_W{1'b1}}) begin
        drop_count_r <= drop_count_r + DROP_W'(1);
      end
    end
  end

  assign out_valid    = !empty;
  assign out_result   = rd_entry_s.result;
  assign out_op       = rd_entry_s.op;
  assign out_flags    = rd_entry_s.flags;
  assign drop_count   = drop_count_r;
  assign overflow_err = overflow_err_r;

endmodule
